// File: rtl/oam_dma_arbiter.sv
// oam_dma_arbiter: arbitrates the system bus between the cpu and the sprite OAM DMA engine
module oam_dma_arbiter #(
  parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
  parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_d_out,
  input  logic        cpu_write,
  output logic        cpu_ready,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_d_out,
  output logic        bus_write,
  input  logic [7:0]  bus_d_in,
  output logic        dma_active
);
  typedef enum logic [2:0] {IDLE, HALT, ALIGN, READ, WRITE} state_t;
  state_t state, state_nxt;
  logic [7:0] page, idx, data;
  logic cyc_odd, trig;
  assign trig = cpu_write && cpu_addr == DMA_REG_ADDR;
  assign cpu_ready = state == IDLE;
  assign dma_active = ~cpu_ready;
  // state register, source page/index, fetched byte and the free-running bus parity
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      page <= '0;
      idx <= '0;
      data <= '0;
      cyc_odd <= 1'b0;
    end else begin
      state <= state_nxt;
      cyc_odd <= ~cyc_odd;
      if (state == IDLE && trig) begin
        page <= cpu_d_out;
        idx <= '0;
      end
      if (state == READ) data <= bus_d_in;
      if (state == WRITE) idx <= idx + 8'd1;
    end
  // next state and bus ownership: cpu passthrough when idle, DMA read/write cycles otherwise
  always_comb begin
    state_nxt = state == IDLE  ? (trig ? HALT : IDLE) :
                state == HALT  ? (cyc_odd ? ALIGN : READ) :
                state == ALIGN ? READ :
                state == READ  ? WRITE :
                                 (idx == 8'hFF ? IDLE : READ);
    bus_addr  = state == READ ? {page, idx} : state == WRITE ? OAM_DATA_ADDR : cpu_addr;
    bus_d_out = state == IDLE ? cpu_d_out : data;
    bus_write = state == IDLE ? cpu_write : state == WRITE;
  end
endmodule

// File: tb/tb_oam_dma_arbiter.sv
// tb_oam_dma_arbiter: randomized bench with a transaction-level bus schedule model
module tb_oam_dma_arbiter;
  logic clk = 1'b0, rst = 1'b0;
  logic [15:0] cpu_addr = '0, bus_addr;
  logic [7:0] cpu_d_out = '0, bus_d_out, bus_d_in;
  logic cpu_write = 1'b0, cpu_ready, bus_write, dma_active;
  logic [7:0] mem [0:65535];
  typedef struct {int kind; logic [15:0] addr; logic [7:0] data;} rec_t;
  rec_t q[$];
  rec_t cur;
  int cnt = 0, checks = 0, errors = 0;
  int stall_cnt = 0, stall_len = 0, oam_count = 0;
  logic [7:0] oam_log [0:255];
  logic [15:0] prev_addr = '0, last_read = '0;
  bit hit_zero = 0;

  oam_dma_arbiter dut (
    .clk(clk), .reset(rst), .cpu_addr(cpu_addr), .cpu_d_out(cpu_d_out),
    .cpu_write(cpu_write), .cpu_ready(cpu_ready), .bus_addr(bus_addr),
    .bus_d_out(bus_d_out), .bus_write(bus_write), .bus_d_in(bus_d_in),
    .dma_active(dma_active)
  );

  assign bus_d_in = mem[bus_addr];
  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", n, a, e, $time);
    end
  endtask

  // Model: a DMA trigger schedules the full list of bus cycles it must produce.
  // kind 0 = stall cycle (cpu addr, no write), 1 = read, 2 = OAM write.
  always @(posedge clk or posedge rst)
    if (rst) begin
      q.delete();
      cnt = 0;
    end else begin
      cnt++;
      if (q.size() != 0) q.pop_front();
      else if (cpu_write && cpu_addr == 16'h4014) begin
        logic [7:0] pg;
        logic [15:0] a;
        pg = cpu_d_out;
        q.push_back('{0, 16'h0, 8'h0});
        if ((cnt & 1) == 1) q.push_back('{0, 16'h0, 8'h0});
        for (int i = 0; i < 256; i++) begin
          a = {pg, 8'(i)};
          q.push_back('{1, a, 8'h0});
          q.push_back('{2, 16'h2004, mem[a]});
        end
      end
    end

  // Compare DUT outputs against the model every cycle
  always @(negedge clk) begin
    if (q.size() == 0) begin
      chk("idle_addr", bus_addr, cpu_addr);
      chk("idle_we", bus_write, cpu_write);
      if (cpu_write) chk("idle_dout", bus_d_out, cpu_d_out);
      chk("idle_ready", cpu_ready, 1);
      chk("idle_active", dma_active, 0);
    end else begin
      cur = q[0];
      chk("dma_ready", cpu_ready, 0);
      chk("dma_active", dma_active, 1);
      chk("dma_addr", bus_addr, cur.kind == 0 ? cpu_addr : cur.addr);
      chk("dma_we", bus_write, cur.kind == 2);
      if (cur.kind == 2) chk("dma_dout", bus_d_out, cur.data);
    end
  end

  // Observe stall length, OAM write data and read addresses straight off the bus
  always @(negedge clk) begin
    if (!cpu_ready) stall_cnt++;
    else if (stall_cnt != 0) begin
      stall_len = stall_cnt;
      stall_cnt = 0;
    end
    if (dma_active && bus_write) begin
      if (oam_count < 256) oam_log[oam_count] = bus_d_out;
      oam_count++;
      last_read = prev_addr;
      if (prev_addr == 16'h0000) hit_zero = 1;
    end
    prev_addr = bus_addr;
  end

  task automatic step(input logic [15:0] a, input logic [7:0] d, input logic w);
    cpu_addr = a;
    cpu_d_out = d;
    cpu_write = w;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_rand();
    logic [15:0] a;
    a = 16'($urandom);
    if (a == 16'h4014) a = 16'h4015;
    step(a, 8'($urandom), 1'($urandom_range(0, 1)));
  endtask

  task automatic busy_rand();
    logic [15:0] a;
    a = $urandom_range(0, 7) == 0 ? 16'h4014 : 16'($urandom);
    step(a, 8'($urandom), 1'($urandom_range(0, 1)));
  endtask

  task automatic start_dma(input logic [7:0] pg, input logic odd);
    while ((cnt & 1) == int'(odd)) idle_rand();
    oam_count = 0;
    hit_zero = 0;
    stall_len = 0;
    step(16'h4014, pg, 1'b1);
  endtask

  task automatic run_dma(input logic [7:0] pg, input logic odd);
    start_dma(pg, odd);
    for (int k = 0; k < 600 && !cpu_ready; k++) busy_rand();
    chk("dma_done", cpu_ready, 1);
    step(16'h0000, 8'h00, 1'b0);
    chk("stall_len", stall_len, odd ? 514 : 513);
    chk("oam_count", oam_count, 256);
  endtask

  task automatic nontrig(input logic [15:0] a, input logic w);
    step(a, 8'h07, w);
    chk("nontrig_active", dma_active, 0);
    chk("nontrig_ready", cpu_ready, 1);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 256; i++) mem[16'h0200 + i] = 8'(i) ^ 8'hA5;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", cpu_ready, 1);
    chk("rst_active", dma_active, 0);
    rst = 1'b0;
    repeat (3) idle_rand();
    cpu_addr = 16'h0300;
    cpu_d_out = 8'h5A;
    cpu_write = 1'b1;
    @(negedge clk);
    chk("pass_addr", bus_addr, 16'h0300);
    chk("pass_dout", bus_d_out, 8'h5A);
    chk("pass_we", bus_write, 1);
    chk("pass_ready", cpu_ready, 1);
    @(posedge clk);
    #1;
    nontrig(16'h4015, 1'b1);
    nontrig(16'h4013, 1'b1);
    nontrig(16'h4014, 1'b0);
    run_dma(8'h02, 1'b0);
    chk("even_first", oam_log[0], 8'hA5);
    chk("even_mid", oam_log[8'h37], 8'h92);
    chk("even_last", oam_log[255], 8'h5A);
    run_dma(8'h02, 1'b1);
    chk("odd_first", oam_log[0], 8'hA5);
    chk("odd_last", oam_log[255], 8'h5A);
    run_dma(8'hFF, 1'($urandom_range(0, 1)));
    chk("wrap_last_read", last_read, 16'hFFFF);
    chk("wrap_no_zero", hit_zero, 0);
    start_dma(8'h02, 1'b0);
    for (int k = 0; k < 600 && oam_count < 100; k++) busy_rand();
    chk("reach_100", oam_count, 100);
    cpu_write = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("abort_ready", cpu_ready, 1);
    chk("abort_active", dma_active, 0);
    chk("abort_we", bus_write, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (5) step(16'h0000, 8'h00, 1'b0);
    chk("abort_no_writes", oam_count, 100);
    run_dma(8'h02, 1'b0);
    chk("restart_first", oam_log[0], 8'hA5);
    chk("restart_second", oam_log[1], 8'hA4);
    repeat (4) begin
      repeat ($urandom_range(1, 10)) idle_rand();
      run_dma(8'($urandom), 1'($urandom_range(0, 1)));
    end
    repeat (3) idle_rand();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
